// File: rtl/gru_grad_sched_pkg.sv
// Shared types and sizing for the GRU gradient sequencer and its state bank.
package gru_grad_sched_pkg;

   localparam int DATABIT = 16;
   localparam int CELLNUM = 4;
   localparam int NW      = (CELLNUM > 1) ? $clog2(CELLNUM) : 1;
   localparam int VECW    = CELLNUM * DATABIT;

   typedef logic [VECW-1:0] vec_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_STORE,
      S_DRAIN
   } state_t;

   // Cell c of a packed per-cell vector; cell 0 sits in the LSBs.
   function automatic logic [DATABIT-1:0] cell_get(input vec_t v, input int c);
      return v[c*DATABIT +: DATABIT];
   endfunction

endpackage

// File: rtl/gru_grad_sched_bank.sv
// Recurrent dh/dW state: CELLNUM words of CELLNUM cells, one write port, two
// combinational read ports; async reset and synchronous clear both zero it.
module grad_bank
   import gru_grad_sched_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_i,
   input  logic            we_i,
   input  logic [NW-1:0]   waddr_i,
   input  logic [VECW-1:0] wdat_i,
   input  logic [NW-1:0]   raddr_a_i,
   input  logic [NW-1:0]   raddr_b_i,
   output logic [VECW-1:0] rdat_a_o,
   output logic [VECW-1:0] rdat_b_o
);

   vec_t mem_q [CELLNUM];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CELLNUM; i++) mem_q[i] <= '0;
      end else if (clr_i) begin
         for (int i = 0; i < CELLNUM; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdat_i;
      end
   end

   assign rdat_a_o = mem_q[raddr_a_i];
   assign rdat_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/gru_grad_sched.sv
// GRU gradient sequencer: per step one operand fetch, CELLNUM datapath issues, then a
// valid/ready drain of the bank. GRU_SCHED_TIMEOUT_EN adds a WAIT watchdog (sticky err).
module gru_grad_sched
   import gru_grad_sched_pkg::*;
#(
   parameter int TSTEPS  = 8,
   parameter int MIN_LAT = 2,
   parameter int TO_CYC  = 64,
   localparam int TW     = (TSTEPS > 1) ? $clog2(TSTEPS) : 1
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            op_req,
   output logic [TW-1:0]   op_t,
   input  logic            op_ack,
   output logic            dp_en,
   output logic [NW-1:0]   dp_n,
   output logic [VECW-1:0] dp_dh,
   input  logic            dp_valid,
   input  logic [VECW-1:0] dp_res,
   output logic            g_valid,
   input  logic            g_ready,
   output logic [NW-1:0]   g_n,
   output logic [VECW-1:0] g_data
);

   localparam int WCW = $clog2(MIN_LAT + TO_CYC + 2);
   localparam logic [TW-1:0]  T_LAST = TW'(TSTEPS - 1);
   localparam logic [NW-1:0]  N_LAST = NW'(CELLNUM - 1);
   localparam logic [WCW-1:0] MIN_C  = WCW'(MIN_LAT);

   state_t          state_q, state_d;
   logic [TW-1:0]   t_q, t_d;
   logic [NW-1:0]   n_q, n_d;
   logic [WCW-1:0]  wcnt_q, wcnt_d;
   logic [VECW-1:0] res_q, res_d;
   logic            done_q, done_d;
   logic [VECW-1:0] dp_dh_q, g_data_q;
   logic            bank_clr, bank_we;
   logic [VECW-1:0] rd_a, rd_b;

`ifdef GRU_SCHED_TIMEOUT_EN
   localparam logic [WCW-1:0] TO_C = WCW'(TO_CYC - 1);
   logic err_q, err_d;
`endif

   grad_bank u_bank (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (bank_clr),
      .we_i      (bank_we),
      .waddr_i   (n_q),
      .wdat_i    (res_q),
      .raddr_a_i (n_d),
      .raddr_b_i (n_d),
      .rdat_a_o  (rd_a),
      .rdat_b_o  (rd_b)
   );

   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      n_d      = n_q;
      wcnt_d   = wcnt_q;
      res_d    = res_q;
      done_d   = 1'b0;
      bank_clr = 1'b0;
      bank_we  = 1'b0;
`ifdef GRU_SCHED_TIMEOUT_EN
      err_d    = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               bank_clr = 1'b1;
               t_d      = '0;
               n_d      = '0;
               state_d  = S_FETCH;
`ifdef GRU_SCHED_TIMEOUT_EN
               err_d    = 1'b0;
`endif
            end
         end
         S_FETCH: begin
            if (op_ack) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            wcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
`ifdef GRU_SCHED_TIMEOUT_EN
            wcnt_d = wcnt_q + WCW'(1);
`else
            if (wcnt_q < MIN_C) wcnt_d = wcnt_q + WCW'(1);
`endif
            // The first MIN_LAT cycles may still show the previous result's valid.
            if (wcnt_q >= MIN_C && dp_valid) begin
               res_d   = dp_res;
               state_d = S_STORE;
            end
`ifdef GRU_SCHED_TIMEOUT_EN
            else if (wcnt_q == TO_C) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               t_d     = '0;
               n_d     = '0;
               state_d = S_IDLE;
            end
`endif
         end
         S_STORE: begin
            bank_we = 1'b1;
            if (n_q != N_LAST) begin
               n_d     = n_q + NW'(1);
               state_d = S_ISSUE;
            end else if (t_q != T_LAST) begin
               n_d     = '0;
               t_d     = t_q + TW'(1);
               state_d = S_FETCH;
            end else begin
               n_d     = '0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (g_ready) begin
               if (n_q == N_LAST) begin
                  n_d     = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  n_d = n_q + NW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Read ports follow n_d, so the registered words line up with n_q; STORE never
   // writes the index being read because n always moves on when it writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         t_q      <= '0;
         n_q      <= '0;
         wcnt_q   <= '0;
         res_q    <= '0;
         done_q   <= 1'b0;
         dp_dh_q  <= '0;
         g_data_q <= '0;
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         n_q      <= n_d;
         wcnt_q   <= wcnt_d;
         res_q    <= res_d;
         done_q   <= done_d;
         dp_dh_q  <= rd_a;
         g_data_q <= (state_d == S_DRAIN) ? rd_b : '0;
      end
   end

`ifdef GRU_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign op_req  = (state_q == S_FETCH);
   assign op_t    = t_q;
   assign dp_en   = (state_q == S_ISSUE);
   assign dp_n    = n_q;
   assign dp_dh   = dp_dh_q;
   assign g_valid = (state_q == S_DRAIN);
   assign g_n     = g_valid ? n_q : '0;
   assign g_data  = g_data_q;

endmodule

// File: tb/tb_gru_grad_sched.sv
// Directed + randomized bench for gru_grad_sched with a behavioural datapath and bank model.
module tb_gru_grad_sched;
   import gru_grad_sched_pkg::*;

   localparam int TS = 3;
   localparam int ML = 2;
   localparam int TO = 64;
   localparam int TW = $clog2(TS);
   localparam int M_CONST = 0, M_INC = 1, M_RAND = 2, M_NONE = 3;

   logic            clk, rst, start, busy, done, err, op_req, op_ack;
   logic [TW-1:0]   op_t;
   logic            dp_en, dp_valid, g_valid, g_ready;
   logic [NW-1:0]   dp_n, g_n;
   logic [VECW-1:0] dp_dh, dp_res, g_data;

   int   tests = 0, fails = 0, cyc = 0;
   int   mode, lat, ack_delay, en_cnt, req_cnt, done_cnt, last_en_cyc;
   bit   stale;
   vec_t exp_bank [CELLNUM];

   gru_grad_sched #(.TSTEPS(TS), .MIN_LAT(ML), .TO_CYC(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .op_req(op_req), .op_t(op_t), .op_ack(op_ack),
      .dp_en(dp_en), .dp_n(dp_n), .dp_dh(dp_dh), .dp_valid(dp_valid), .dp_res(dp_res),
      .g_valid(g_valid), .g_ready(g_ready), .g_n(g_n), .g_data(g_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {busy, done, err, op_req, op_t, dp_en, dp_n, g_valid, g_n}, 0);
      chk({tag, "_dp_dh"}, dp_dh, 0);
      chk({tag, "_g_data"}, g_data, 0);
   endtask

   function automatic vec_t model(input vec_t dh, input int n);
      vec_t v = '0;
      for (int c = 0; c < CELLNUM; c++) begin
         case (mode)
            M_CONST: v[c*DATABIT +: DATABIT] = DATABIT'(16 * (n + 1));
            M_INC:   v[c*DATABIT +: DATABIT] = cell_get(dh, c) + DATABIT'(1);
            default: v[c*DATABIT +: DATABIT] = DATABIT'($urandom);
         endcase
      end
      return v;
   endfunction

   // Issue-to-issue spacing: capture no earlier than MIN_LAT+1 after dp_en, then STORE, ISSUE.
   function automatic int exp_gap();
      if (stale) return ML + 3;
      return ((lat > ML + 1) ? lat : ML + 1) + 2;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Operand store: acks after ack_delay cycles of op_req, random noise otherwise.
   initial begin
      int ac = 0;
      op_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (op_req === 1'b1) begin
            ac++;
            op_ack = (ac > ack_delay);
         end else begin
            ac = 0;
            op_ack = 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      logic          prev_req = 1'b0;
      logic [TW-1:0] prev_t = '0;
      forever begin
         @(posedge clk); #1;
         if (op_req === 1'b1) begin
            if (prev_req) chk("op_t_hold", op_t, prev_t);
            else begin
               req_cnt++;
               chk("op_t_step", op_t, req_cnt - 1);
            end
         end
         if (done === 1'b1) done_cnt++;
         prev_req = op_req;
         prev_t   = op_t;
      end
   end

   // Datapath model and bank scoreboard.
   initial begin
      vec_t r;
      int   n;
      dp_valid = 1'b0;
      dp_res   = '0;
      forever begin
         @(posedge clk); #1;
         if (dp_en === 1'b1) begin
            n = en_cnt % CELLNUM;
            chk("dp_n", dp_n, n);
            chk("dp_step", op_t, en_cnt / CELLNUM);
            chk("dp_dh", dp_dh, exp_bank[n]);
            if (n != 0) chk("issue_gap", cyc - last_en_cyc, exp_gap());
            last_en_cyc = cyc;
            en_cnt++;
            if (!stale) dp_valid = 1'b0;
            r = model(dp_dh, n);
            if (mode != M_NONE) exp_bank[n] = r;
            if (stale) dp_res = r;
            else if (mode != M_NONE) begin
               repeat (lat) @(posedge clk);
               #1;
               dp_valid = 1'b1;
               dp_res   = r;
            end
         end
      end
   end

   task automatic begin_seq(input int m, input int l, input bit st, input int ad);
      mode = m; lat = l; stale = st; ack_delay = ad;
      en_cnt = 0; req_cnt = 0; done_cnt = 0;
      for (int i = 0; i < CELLNUM; i++) exp_bank[i] = '0;
      dp_valid = st;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("err_after_start", err, 0);
   endtask

   task automatic finish_seq(input bit bp);
      int k = 0;
      while (g_valid !== 1'b1 && k < 4000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain_reached", g_valid, 1);
      chk("issue_count", en_cnt, TS * CELLNUM);
      chk("req_count", req_cnt, TS);
      for (int b = 0; b < CELLNUM; b++) begin
         if (bp) begin
            g_ready = 1'b0;
            repeat (10) begin
               @(posedge clk); #1;
               chk("bp_valid", g_valid, 1);
               chk("bp_n", g_n, b);
               chk("bp_data", g_data, exp_bank[b]);
               chk("bp_nodone", done, 0);
            end
         end
         chk("g_valid", g_valid, 1);
         chk("g_n", g_n, b);
         chk("g_data", g_data, exp_bank[b]);
         for (int c = 0; c < CELLNUM; c++) begin
            if (mode == M_INC)   chk("recur_cell", cell_get(g_data, c), TS);
            if (mode == M_CONST) chk("const_cell", cell_get(g_data, c), 16 * (b + 1));
         end
         g_ready = 1'b1;
         @(posedge clk); #1;
         g_ready = 1'b0;
      end
      chk("done_pulse", done, 1);
      chk("gvalid_off", g_valid, 0);
      chk("idle_after", busy, 0);
      @(posedge clk); #1;
      chk("done_once", done_cnt, 1);
      chk("done_drop", done, 0);
   endtask

   initial begin
      int k;
      int t0;
      rst = 1'b1; start = 1'b0; g_ready = 1'b0;
      mode = M_CONST; lat = 5; stale = 1'b0; ack_delay = 0;
      en_cnt = 0; req_cnt = 0; done_cnt = 0; last_en_cyc = 0;
      repeat (3) @(posedge clk); #1;
      chk_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);

      begin_seq(M_CONST, 5, 1'b0, 0); finish_seq(1'b0);
      begin_seq(M_INC,   5, 1'b0, 0); finish_seq(1'b0);
      begin_seq(M_CONST, 5, 1'b0, 0); finish_seq(1'b1);
      begin_seq(M_RAND,  0, 1'b1, 7); finish_seq(1'b0);

      begin_seq(M_RAND, 5, 1'b0, 0);
      k = 0;
      while (!(dp_en === 1'b1 && req_cnt == 2) && k < 2000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reached_t1", req_cnt, 2);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("async_busy", busy, 0);
      @(posedge clk); #1;
      chk_zero("midrst");
      rst = 1'b0;
      repeat (10) @(posedge clk); #1;
      begin_seq(M_INC, 4, 1'b0, 1); finish_seq(1'b0);

      for (int i = 0; i < 4; i++) begin
         begin_seq(M_RAND, $urandom_range(1, 6), 1'b0, $urandom_range(0, 3));
         repeat (4) @(posedge clk); #1;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         finish_seq(1'($urandom_range(0, 1)));
      end

`ifdef GRU_SCHED_TIMEOUT_EN
      begin_seq(M_NONE, 0, 1'b0, 0);
      k = 0;
      while (dp_en !== 1'b1 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk("to_issue", dp_en, 1);
      t0 = cyc;
      k = 0;
      while (done !== 1'b1 && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      chk("to_gap", cyc - t0, TO + 1);
      chk("to_err", err, 1);
      chk("to_idle", busy, 0);
      chk("to_nodrain", g_valid, 0);
      @(posedge clk); #1;
      chk("err_sticky", err, 1);
      begin_seq(M_CONST, 5, 1'b0, 0); finish_seq(1'b0);
`else
      t0 = cyc;
      chk("err_tied", err, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
